// File: rtl/axi4_slave_pkg.sv
// axi4_slave_pkg: burst/response encodings, write FSM states and the AR FIFO entry
// shared by the AXI4 slave memory and its address generator.
package axi4_slave_pkg;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_ID_W = 4;
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11} burst_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [AXI_ID_W-1:0]   id;
        logic [7:0]            len;
        burst_e                burst;
    } ar_entry_t;
endpackage

// File: rtl/axi4_burst_addr_gen.sv
// axi4_burst_addr_gen: next beat address and burst legality for a full-width AXI4 burst.
// Legality depends only on the low address bits, which stay constant across a legal burst.
module axi4_burst_addr_gen
    import axi4_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [7:0]            len_i,
    input  burst_e                burst_i,
    output logic [ADDR_WIDTH-1:0] next_addr_o,
    output logic                  legal_o
);
    localparam int LSB = $clog2(DATA_WIDTH / 8);
    logic [ADDR_WIDTH-1:0] inc, mask;
    always_comb begin
        inc = addr_i + ADDR_WIDTH'(DATA_WIDTH / 8);
        mask = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << LSB) - ADDR_WIDTH'(1);
        next_addr_o = burst_i == FIXED ? addr_i : burst_i == WRAP ? (addr_i & ~mask) | (inc & mask) : inc;
        legal_o = burst_i == RSVD ? 1'b0 : burst_i != WRAP ? 1'b1 :
                  (len_i inside {8'd1, 8'd3, 8'd7, 8'd15}) && addr_i[LSB-1:0] == '0;
    end
endmodule

// File: rtl/axi4_slave_mem.sv
// axi4_slave_mem: AXI4 slave backed by an on-chip word array, with a single write
// burst in flight and a queue of outstanding read bursts streamed in order.
module axi4_slave_mem
    import axi4_slave_pkg::*;
#(
    parameter int ADDR_WIDTH    = AXI_ADDR_W,
    parameter int DATA_WIDTH    = 32,
    parameter int ID_WIDTH      = AXI_ID_W,
    parameter int MEM_DEPTH     = 1024,
    parameter int AR_FIFO_DEPTH = 4
) (
    input  logic                    CLK_1,
    input  logic                    RESET_1,
    input  logic [ADDR_WIDTH-1:0]   dma_m_awaddr,
    input  logic [ID_WIDTH-1:0]     dma_m_awid,
    input  logic [7:0]              dma_m_awlen,
    input  logic [1:0]              dma_m_awburst,
    input  logic                    dma_m_awvalid,
    output logic                    dma_m_awready,
    input  logic [DATA_WIDTH-1:0]   dma_m_wdata,
    input  logic [DATA_WIDTH/8-1:0] dma_m_wstrb,
    input  logic                    dma_m_wlast,
    input  logic                    dma_m_wvalid,
    output logic                    dma_m_wready,
    output logic [ID_WIDTH-1:0]     dma_m_bid,
    output logic [1:0]              dma_m_bresp,
    output logic                    dma_m_bvalid,
    input  logic                    dma_m_bready,
    input  logic [ADDR_WIDTH-1:0]   dma_m_araddr,
    input  logic [ID_WIDTH-1:0]     dma_m_arid,
    input  logic [7:0]              dma_m_arlen,
    input  logic [1:0]              dma_m_arburst,
    input  logic                    dma_m_arvalid,
    output logic                    dma_m_arready,
    output logic [DATA_WIDTH-1:0]   dma_m_rdata,
    output logic [ID_WIDTH-1:0]     dma_m_rid,
    output logic [1:0]              dma_m_rresp,
    output logic                    dma_m_rlast,
    output logic                    dma_m_rvalid,
    input  logic                    dma_m_rready
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB = $clog2(BYTES);
    localparam int IW = $clog2(MEM_DEPTH);
    localparam int PW = $clog2(AR_FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * BYTES);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic rdy_q;

    wstate_e wstate_q, wstate_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d, waddr_nxt;
    logic [ID_WIDTH-1:0] wid_q, wid_d;
    logic [7:0] wlen_q, wlen_d, wcnt_q, wcnt_d;
    burst_e wburst_q, wburst_d;
    logic werr_q, werr_d, wlegal, w_fire, w_last, w_inr;

    ar_entry_t fifo_q [AR_FIFO_DEPTH];
    ar_entry_t head;
    logic [PW:0] wptr_q, rptr_q, ocnt_q, ocnt_d;
    logic push, pop, out_ld, r_last, r_ok, r_done;
    logic ract_q, ract_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, raddr_nxt;
    logic [7:0] rlen_q, rlen_d, rcnt_q, rcnt_d;
    burst_e rburst_q, rburst_d;
    logic [ID_WIDTH-1:0] rcid_q, rcid_d, rid_q, rid_d;
    logic rlegal, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0] rresp_q, rresp_d;

    axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_wgen (
        .addr_i(waddr_q), .len_i(wlen_q), .burst_i(wburst_q), .next_addr_o(waddr_nxt), .legal_o(wlegal)
    );
    axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_rgen (
        .addr_i(raddr_q), .len_i(rlen_q), .burst_i(rburst_q), .next_addr_o(raddr_nxt), .legal_o(rlegal)
    );

    assign w_fire = dma_m_wvalid && dma_m_wready;
    assign w_last = wcnt_q == wlen_q;
    assign w_inr = waddr_q < MEM_BYTES;

    always_ff @(posedge CLK_1 or negedge RESET_1)
        if (!RESET_1) begin
            wstate_q <= W_IDLE;
            waddr_q <= '0;
            wid_q <= '0;
            wlen_q <= '0;
            wburst_q <= FIXED;
            wcnt_q <= '0;
            werr_q <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            waddr_q <= waddr_d;
            wid_q <= wid_d;
            wlen_q <= wlen_d;
            wburst_q <= wburst_d;
            wcnt_q <= wcnt_d;
            werr_q <= werr_d;
        end

    always_comb begin
        wstate_d = wstate_q;
        waddr_d = waddr_q;
        wid_d = wid_q;
        wlen_d = wlen_q;
        wburst_d = wburst_q;
        wcnt_d = wcnt_q;
        werr_d = werr_q;
        if (dma_m_awvalid && dma_m_awready) begin
            wstate_d = W_DATA;
            waddr_d = dma_m_awaddr;
            wid_d = dma_m_awid;
            wlen_d = dma_m_awlen;
            wburst_d = burst_e'(dma_m_awburst);
            wcnt_d = '0;
            werr_d = 1'b0;
        end
        if (w_fire) begin
            waddr_d = waddr_nxt;
            wcnt_d = wcnt_q + 8'd1;
            werr_d = werr_q || !wlegal || !w_inr || (dma_m_wlast != w_last);
            wstate_d = w_last ? W_RESP : W_DATA;
        end
        if (dma_m_bvalid && dma_m_bready)
            wstate_d = W_IDLE;
    end

    always_comb begin
        dma_m_awready = rdy_q && wstate_q == W_IDLE;
        dma_m_wready = wstate_q == W_DATA;
        dma_m_bvalid = wstate_q == W_RESP;
        dma_m_bid = wid_q;
        dma_m_bresp = werr_q ? SLVERR : OKAY;
    end

    always_ff @(posedge CLK_1)
        if (w_fire && wlegal && w_inr)
            for (int b = 0; b < BYTES; b++)
                if (dma_m_wstrb[b])
                    mem_q[waddr_q[LSB+IW-1:LSB]][b*8 +: 8] <= dma_m_wdata[b*8 +: 8];

    always_ff @(posedge CLK_1)
        if (push)
            fifo_q[wptr_q[PW-1:0]] <= '{addr: AXI_ADDR_W'(dma_m_araddr), id: AXI_ID_W'(dma_m_arid),
                                       len: dma_m_arlen, burst: burst_e'(dma_m_arburst)};

    // Outstanding count covers queued, active and presented bursts until their rlast handshake.
    always_comb begin
        head = fifo_q[rptr_q[PW-1:0]];
        push = dma_m_arvalid && dma_m_arready;
        out_ld = ract_q && (!rvalid_q || dma_m_rready);
        r_last = rcnt_q == rlen_q;
        r_ok = rlegal && raddr_q < MEM_BYTES;
        r_done = rvalid_q && dma_m_rready && rlast_q;
        pop = (!ract_q || (out_ld && r_last)) && wptr_q != rptr_q;
        ocnt_d = ocnt_q + (PW+1)'(push) - (PW+1)'(r_done);
        ract_d = ract_q;
        raddr_d = raddr_q;
        rlen_d = rlen_q;
        rburst_d = rburst_q;
        rcid_d = rcid_q;
        rcnt_d = rcnt_q;
        rvalid_d = rvalid_q && !dma_m_rready;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        rlast_d = rlast_q;
        rid_d = rid_q;
        if (out_ld) begin
            rvalid_d = 1'b1;
            rdata_d = r_ok ? mem_q[raddr_q[LSB+IW-1:LSB]] : '0;
            rresp_d = r_ok ? OKAY : SLVERR;
            rlast_d = r_last;
            rid_d = rcid_q;
            raddr_d = raddr_nxt;
            rcnt_d = rcnt_q + 8'd1;
            ract_d = !r_last;
        end
        if (pop) begin
            ract_d = 1'b1;
            raddr_d = ADDR_WIDTH'(head.addr);
            rlen_d = head.len;
            rburst_d = head.burst;
            rcid_d = ID_WIDTH'(head.id);
            rcnt_d = '0;
        end
    end

    always_ff @(posedge CLK_1 or negedge RESET_1)
        if (!RESET_1) begin
            rdy_q <= 1'b0;
            wptr_q <= '0;
            rptr_q <= '0;
            ocnt_q <= '0;
            ract_q <= 1'b0;
            raddr_q <= '0;
            rlen_q <= '0;
            rburst_q <= FIXED;
            rcid_q <= '0;
            rcnt_q <= '0;
            rvalid_q <= 1'b0;
            rdata_q <= '0;
            rresp_q <= OKAY;
            rlast_q <= 1'b0;
            rid_q <= '0;
        end else begin
            rdy_q <= 1'b1;
            wptr_q <= wptr_q + (PW+1)'(push);
            rptr_q <= rptr_q + (PW+1)'(pop);
            ocnt_q <= ocnt_d;
            ract_q <= ract_d;
            raddr_q <= raddr_d;
            rlen_q <= rlen_d;
            rburst_q <= rburst_d;
            rcid_q <= rcid_d;
            rcnt_q <= rcnt_d;
            rvalid_q <= rvalid_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
            rlast_q <= rlast_d;
            rid_q <= rid_d;
        end

    assign dma_m_arready = rdy_q && ocnt_q != (PW+1)'(AR_FIFO_DEPTH);
    assign dma_m_rvalid = rvalid_q;
    assign dma_m_rdata = rdata_q;
    assign dma_m_rresp = rresp_q;
    assign dma_m_rlast = rlast_q;
    assign dma_m_rid = rid_q;
endmodule

// File: doc/axi4_slave_mem.md
# axi4_slave_mem

Synthesizable AXI4 slave memory responder for the DMA bench. It accepts the DMA master's `dma_m_*` AXI4 traffic and backs it with an on-chip word array. It supports FIXED/INCR/WRAP bursts, byte strobes, out-of-range SLVERR, and a queue of outstanding reads. It generalises the passive slave signal bundle into an active, parametrised endpoint that sits between the DMA master port and the scoreboard's memory view.

## Interface
- `ADDR_WIDTH`, default 32: byte address width.
- `DATA_WIDTH`, default 32: bus width (32/64/128); `BYTES=DATA_WIDTH/8`, `LSB=log2(BYTES)`.
- `ID_WIDTH`, default 4: transaction ID width.
- `MEM_DEPTH`, default 1024: words in the array (power of 2).
- `AR_FIFO_DEPTH`, default 4: outstanding read bursts accepted (power of 2, ≥2).
- `CLK_1` input 1: single clock, rising edge.
- `RESET_1` input 1: asynchronous, active-low reset.
- `dma_m_awaddr` input ADDR_WIDTH: write start byte address.
- `dma_m_awid` input ID_WIDTH: write ID.
- `dma_m_awlen` input 8: beats-1.
- `dma_m_awburst` input 2: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- `dma_m_awvalid` input 1 / `dma_m_awready` output 1: AW handshake.
- `dma_m_wdata` input DATA_WIDTH: write data.
- `dma_m_wstrb` input BYTES: byte enables.
- `dma_m_wlast` input 1: master's last-beat flag.
- `dma_m_wvalid` input 1 / `dma_m_wready` output 1: W handshake.
- `dma_m_bid` output ID_WIDTH: echoed awid.
- `dma_m_bresp` output 2: 00 OKAY, 10 SLVERR.
- `dma_m_bvalid` output 1 / `dma_m_bready` input 1: B handshake.
- `dma_m_araddr` input ADDR_WIDTH: read start byte address.
- `dma_m_arid` input ID_WIDTH: read ID.
- `dma_m_arlen` input 8: beats-1.
- `dma_m_arburst` input 2: same encoding as awburst.
- `dma_m_arvalid` input 1 / `dma_m_arready` output 1: AR handshake.
- `dma_m_rdata` output DATA_WIDTH: read data.
- `dma_m_rid` output ID_WIDTH: echoed arid.
- `dma_m_rresp` output 2: per-beat response.
- `dma_m_rlast` output 1: final beat.
- `dma_m_rvalid` output 1 / `dma_m_rready` input 1: R handshake.

## Operation
- Transfers are always full width, so size is implied as LSB. Word index is `addr[LSB+log2(MEM_DEPTH)-1:LSB]`. A beat is in range when `addr < MEM_DEPTH*BYTES`.
- **Address generation** (per beat):
  - FIXED: the address stays constant.
  - INCR: the address advances by BYTES.
  - WRAP: the address wraps within a window of `(len+1)*BYTES`, aligned to that size.
  - WRAP with len not in {1,3,7,15} or an unaligned start, and burst type 11, make the whole burst an error.
- **Write FSM**:
  - W_IDLE (awready=1): an AW handshake latches addr, id, len and burst, clears the error flag, and moves to W_DATA.
  - W_DATA (wready=1): each beat writes the strobed bytes if the beat is in range and the burst is legal; otherwise it sets the error flag and leaves memory untouched. The burst ends on beat number awlen. A wlast value that disagrees with the beat count sets the error flag. The FSM then moves to W_RESP.
  - W_RESP (bvalid=1): bresp is SLVERR if the error flag is set, else OKAY. A handshake with bready returns to W_IDLE.
- **Read path**:
  - AR requests are pushed into a FIFO, and `arready = !full`.
  - The R engine pops the head entry and streams len+1 beats in order.
  - An out-of-range beat or an illegal burst returns rdata=0 with rresp=SLVERR; all other beats return OKAY.
- Read and write paths are independent. A same-cycle write and read to the same word returns the old data (read-first).

## Timing
- **Reset**: asserting RESET_1 forces every output valid/ready low immediately, and `bresp`, `rresp`, `bid`, `rid`, `rdata` and `rlast` to 0. The FIFO empties and in-flight bursts are abandoned. Memory contents are retained.
- **After reset release**: awready=1 and arready=1 from the first clock edge.
- **Write latency**: wready rises the cycle after the AW handshake. bvalid rises the cycle after the final W handshake.
- **Read latency**: first rvalid appears 2 cycles after the AR handshake when the FIFO was empty. Beats then run 1 per cycle while rready=1. rvalid, rdata, rresp and rlast hold stable while rready=0.
- **Back-to-back reads**: the next burst's first beat follows the previous rlast handshake with zero bubble.
- **FIFO full boundary**: arready deasserts the cycle a push fills the FIFO. A pop and a push in the same cycle while full are both accepted only if arready was already high.

## Structure
- `axi4_slave_pkg`: burst enum (FIXED/INCR/WRAP/RSVD), response constants OKAY=2'b00 and SLVERR=2'b10, and the AR FIFO entry struct {addr, id, len, burst}.
- `axi4_burst_addr_gen`: combinational next-address and legality sub-module, instantiated once on the write side and once on the read side.

## Test plan
- **INCR write then read**: AW addr=0x10, len=3, INCR; data 0xA0..0xA3 with all strobes. Expect bresp=OKAY and bid echoed. AR of the same burst returns 0xA0..0xA3, with rlast on beat 3.
- **WRAP read**: AR addr=0x38, len=3, WRAP with DATA_WIDTH=32. Expect words read at 0x38, 0x3C, 0x30, 0x34. WRAP with len=2 returns SLVERR on all 3 beats.
- **Strobes**: write 0xFFFFFFFF, then 0x00000000 with wstrb=4'b0101. Readback is 0xFF00FF00.
- **Out-of-range write**: write a burst straddling MEM_DEPTH*BYTES. Expect bresp=SLVERR, the in-range beats written, and no other memory changed.
- **AR backpressure**: issue 5 ARs with rready=0. Expect arready low after 4 accepted. Releasing rready returns all bursts in order with the correct rid.
- **Reset mid-burst**: assert RESET_1 mid-burst. rvalid and wready drop immediately. After release a new burst completes with OKAY and the memory retains its earlier data.
